// File: rtl/float8_mult.sv
// Registered 8-bit float multiplier: sign[7], exponent[6:4] (bias 4), fraction[3:0]
// with hidden 1. Single-cycle latency, truncating, saturating on overflow.
module float8_mult (
  input  logic       clk,
  input  logic       rst,
  input  logic       iValid,
  input  logic [7:0] iNum1,
  input  logic [7:0] iNum2,
  output logic [7:0] oNum,
  output logic       overflow,
  output logic       oValid
);

  logic              sign;
  logic              isZero;
  logic [9:0]        sig1;
  logic [9:0]        sig2;
  logic [9:0]        sigProd;
  logic [5:0]        sigHi;
  logic              norm;
  logic [3:0]        frac;
  logic signed [5:0] exp1;
  logic signed [5:0] exp2;
  logic signed [5:0] expUnb;
  logic [2:0]        expCode;
  logic [7:0]        nextNum;
  logic              nextOvf;

  always_comb begin
    sign    = iNum1[7] ^ iNum2[7];
    isZero  = (iNum1[6:0] == 7'h00) || (iNum2[6:0] == 7'h00);
    sig1    = {5'b0, 1'b1, iNum1[3:0]};
    sig2    = {5'b0, 1'b1, iNum2[3:0]};
    sigProd = sig1 * sig2;
    // Bits below the retained fraction are simply discarded: round toward zero.
    sigHi   = 6'(sigProd >> 4);
    norm    = sigHi[5];
    frac    = norm ? sigHi[4:1] : sigHi[3:0];
    exp1    = $signed({3'b0, iNum1[6:4]}) - 6'sd4;
    exp2    = $signed({3'b0, iNum2[6:4]}) - 6'sd4;
    expUnb  = exp1 + exp2 + $signed({5'b0, norm});
    expCode = 3'(expUnb + 6'sd4);

    nextNum = '0;
    nextOvf = 1'b0;
    if (isZero) begin
      nextNum = '0;
    end else if (expUnb > 6'sd3) begin
      nextNum = {sign, 7'h7F};
      nextOvf = 1'b1;
    end else if (expUnb < -6'sd4) begin
      nextNum = '0;
    end else if (expCode == 3'd0 && frac == 4'd0) begin
      // Exponent code 000 with empty fraction aliases the zero encoding.
      nextNum = '0;
    end else begin
      nextNum = {sign, expCode, frac};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      oNum     <= '0;
      overflow <= 1'b0;
      oValid   <= 1'b0;
    end else begin
      oValid <= iValid;
      if (iValid) begin
        oNum     <= nextNum;
        overflow <= nextOvf;
      end
    end
  end

endmodule

// File: tb/tb_float8_mult.sv
// Directed-vector bench for float8_mult with hand-computed expected products.
module tb_float8_mult;

  logic       clk = 1'b0;
  logic       rst;
  logic       iValid;
  logic [7:0] iNum1;
  logic [7:0] iNum2;
  logic [7:0] oNum;
  logic       overflow;
  logic       oValid;

  int errors = 0;
  int checks = 0;

  float8_mult dut (
    .clk      (clk),
    .rst      (rst),
    .iValid   (iValid),
    .iNum1    (iNum1),
    .iNum2    (iNum2),
    .oNum     (oNum),
    .overflow (overflow),
    .oValid   (oValid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%02h expected=%02h", tag, got, exp);
    end
  endtask

  // Drive one cycle's inputs on the falling edge, sample 1 ns after the rising edge.
  task automatic cycle(input string tag, input logic r, input logic v,
                       input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] expNum, input logic expOvf, input logic expValid);
    @(negedge clk);
    rst    = r;
    iValid = v;
    iNum1  = a;
    iNum2  = b;
    @(posedge clk);
    #1;
    check({tag, ".num"}, oNum, expNum);
    check({tag, ".ovf"}, {7'b0, overflow}, {7'b0, expOvf});
    check({tag, ".vld"}, {7'b0, oValid}, {7'b0, expValid});
  endtask

  typedef struct {
    string      tag;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] num;
    logic       ovf;
  } vec_t;

  vec_t vecs[$];

  initial begin
    rst    = 1'b1;
    iValid = 1'b1;
    iNum1  = 8'h38;
    iNum2  = 8'h38;

    vecs.push_back('{"basic",     8'h1D, 8'h2C, 8'h09, 1'b0});
    vecs.push_back('{"normNeg",   8'h38, 8'hB8, 8'hB2, 1'b0});
    vecs.push_back('{"truncNeg",  8'h43, 8'hA3, 8'hA6, 1'b0});
    vecs.push_back('{"signNeg",   8'h20, 8'hB5, 8'h95, 1'b0});
    vecs.push_back('{"zeroA",     8'h00, 8'hB3, 8'h00, 1'b0});
    vecs.push_back('{"negZeroB",  8'hC5, 8'h80, 8'h00, 1'b0});
    vecs.push_back('{"maxOk",     8'h7F, 8'h3F, 8'h7E, 1'b0});
    vecs.push_back('{"ovfPos",    8'h7F, 8'h50, 8'h7F, 1'b1});
    vecs.push_back('{"ovfNeg",    8'hFF, 8'h50, 8'hFF, 1'b1});
    vecs.push_back('{"ovfNorm",   8'hF8, 8'h48, 8'hFF, 1'b1});
    vecs.push_back('{"underflow", 8'h10, 8'h10, 8'h00, 1'b0});
    vecs.push_back('{"aliasZero", 8'h20, 8'hA0, 8'h00, 1'b0});
    vecs.push_back('{"minNonZ",   8'h21, 8'h20, 8'h01, 1'b0});

    // Reset held with a valid pair present: that pair must never emerge.
    cycle("rst0", 1'b1, 1'b1, 8'h38, 8'h38, 8'h00, 1'b0, 1'b0);
    cycle("rst1", 1'b1, 1'b1, 8'h7F, 8'h50, 8'h00, 1'b0, 1'b0);
    cycle("idle", 1'b0, 1'b0, 8'h7F, 8'h50, 8'h00, 1'b0, 1'b0);

    // Back-to-back stream of every vector.
    foreach (vecs[i])
      cycle(vecs[i].tag, 1'b0, 1'b1, vecs[i].a, vecs[i].b, vecs[i].num, vecs[i].ovf, 1'b1);

    // Gap holds the last result with oValid low.
    cycle("gapHold0", 1'b0, 1'b0, 8'h7F, 8'h50, 8'h01, 1'b0, 1'b0);
    cycle("preOvf",   1'b0, 1'b1, 8'h7F, 8'h50, 8'h7F, 1'b1, 1'b1);
    cycle("gapHold1", 1'b0, 1'b0, 8'h1D, 8'h2C, 8'h7F, 1'b1, 1'b0);

    // Mid-stream reset: cleared outputs, in-reset pair lost, then one-cycle latency resumes.
    cycle("s0",     1'b0, 1'b1, 8'h38, 8'hB8, 8'hB2, 1'b0, 1'b1);
    cycle("sRst",   1'b1, 1'b1, 8'h43, 8'hA3, 8'h00, 1'b0, 1'b0);
    cycle("s1",     1'b0, 1'b1, 8'h20, 8'hB5, 8'h95, 1'b0, 1'b1);
    cycle("s2",     1'b0, 1'b1, 8'hFF, 8'h50, 8'hFF, 1'b1, 1'b1);
    cycle("sGap",   1'b0, 1'b0, 8'h43, 8'hA3, 8'hFF, 1'b1, 1'b0);
    cycle("s3",     1'b0, 1'b1, 8'h1D, 8'h2C, 8'h09, 1'b0, 1'b1);
    cycle("sTail",  1'b0, 1'b0, 8'h00, 8'h00, 8'h09, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
